sim_end_ctrl: RTL and testbench

//  Testbench-side controller that decides when a simulation run ends. It watches the

---
 rtl/sim_ctrl_pkg.sv | 19 +
 rtl/sim_sat_cnt.sv | 23 ++
 rtl/sim_end_ctrl.sv | 125 ++++++++++++
 tb/tb_sim_end_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation-end controller: cause codes and FSM states.
package sim_ctrl_pkg;

  localparam int CAUSE_W = 2;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_BREAK = 2'd1,
    CAUSE_EXT   = 2'd2,
    CAUSE_WDOG  = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sim_sat_cnt.sv
// Saturating up-counter with clear and hold; sticks at all-ones instead of wrapping.
module sim_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear wins over increment; increment stops at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sim_end_ctrl.sv
// Decides when a simulation run ends: break commit, external stop or commit watchdog,
// followed by a fixed drain period, then a sticky finish flag with cause, exit code and PC.
module sim_end_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int WDOG_CYCLES  = 10000,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               commit_valid,
  input  logic               commit_is_break,
  input  logic [31:0]        commit_pc,
  input  logic [31:0]        commit_a0,
  input  logic               ext_stop,
  output logic               running,
  output logic               finish,
  output logic [CAUSE_W-1:0] cause,
  output logic [31:0]        exit_code,
  output logic [31:0]        stop_pc,
  output logic [CNT_W-1:0]   inst_cnt,
  output logic [CNT_W-1:0]   cycle_cnt
);

  localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;
  localparam logic [31:0] WDOG_LAST  = (WDOG_CYCLES  > 0) ? 32'(WDOG_CYCLES  - 1) : 32'd0;
  localparam bit          WDOG_EN    = (WDOG_CYCLES  > 0);
  localparam bit          NO_DRAIN   = (DRAIN_CYCLES == 0);

  state_e      state;
  logic [31:0] last_pc;
  logic [31:0] drain_cnt;
  logic [31:0] wdog_cnt;

  logic in_run;
  logic brk_hit;
  logic wdog_hit;
  logic trig;

  // Commit-side qualifiers: commit_* fields only matter when commit_valid is high,
  // so an X on them while idle never reaches a register.
  assign in_run   = (state == ST_RUN);
  assign brk_hit  = commit_valid & commit_is_break;
  assign wdog_hit = WDOG_EN & (wdog_cnt == WDOG_LAST) & ~commit_valid;
  assign trig     = in_run & (brk_hit | ext_stop | wdog_hit);

  sim_sat_cnt #(.W(CNT_W)) u_inst_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (in_run & commit_valid),
    .clr   (1'b0),
    .cnt   (inst_cnt)
  );

  sim_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state != ST_DONE),
    .clr   (1'b0),
    .cnt   (cycle_cnt)
  );

  sim_sat_cnt #(.W(32)) u_wdog_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (in_run & ~commit_valid),
    .clr   (in_run & commit_valid),
    .cnt   (wdog_cnt)
  );

  // RUN -> DRAIN -> DONE controller with cause/PC capture on the trigger edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      running   <= 1'b1;
      finish    <= 1'b0;
      cause     <= CAUSE_NONE;
      exit_code <= 32'd0;
      stop_pc   <= 32'd0;
      last_pc   <= 32'd0;
      drain_cnt <= 32'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (commit_valid) begin
            last_pc <= commit_pc;
          end
          if (trig) begin
            if (brk_hit) begin
              cause     <= CAUSE_BREAK;
              exit_code <= commit_a0;
              stop_pc   <= commit_pc;
            end else if (ext_stop) begin
              cause     <= CAUSE_EXT;
              exit_code <= 32'd0;
              stop_pc   <= commit_valid ? commit_pc : last_pc;
            end else begin
              cause     <= CAUSE_WDOG;
              exit_code <= 32'd0;
              stop_pc   <= last_pc;
            end
            running   <= 1'b0;
            drain_cnt <= DRAIN_LOAD;
            state     <= NO_DRAIN ? ST_DONE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 32'd0) begin
            state <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt - 32'd1;
          end
        end
        ST_DONE: begin
          finish <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_end_ctrl.sv
// Scoreboard bench for sim_end_ctrl: one instance with drain/watchdog, one with
// no drain and narrow saturating counters.
module tb_sim_end_ctrl;
  import sim_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: DRAIN_CYCLES=4, WDOG_CYCLES=16, CNT_W=32
  logic        rst_a = 1'b0, cv_a = 1'b0, brk_a = 1'b0, es_a = 1'b0;
  logic [31:0] pc_a = '0, a0_a = '0;
  logic        run_a, fin_a;
  logic [1:0]  cause_a;
  logic [31:0] exit_a, spc_a, inst_a, ccnt_a;

  // Instance B: DRAIN_CYCLES=0, WDOG_CYCLES=0, CNT_W=4
  logic        rst_b = 1'b0, cv_b = 1'b0, brk_b = 1'b0, es_b = 1'b0;
  logic [31:0] pc_b = '0, a0_b = '0;
  logic        run_b, fin_b;
  logic [1:0]  cause_b;
  logic [31:0] exit_b, spc_b;
  logic [3:0]  inst_b, ccnt_b;

  sim_end_ctrl #(.DRAIN_CYCLES(4), .WDOG_CYCLES(16), .CNT_W(32)) dut_a (
    .clk(clk), .reset(rst_a), .commit_valid(cv_a), .commit_is_break(brk_a),
    .commit_pc(pc_a), .commit_a0(a0_a), .ext_stop(es_a), .running(run_a),
    .finish(fin_a), .cause(cause_a), .exit_code(exit_a), .stop_pc(spc_a),
    .inst_cnt(inst_a), .cycle_cnt(ccnt_a)
  );

  sim_end_ctrl #(.DRAIN_CYCLES(0), .WDOG_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .commit_valid(cv_b), .commit_is_break(brk_b),
    .commit_pc(pc_b), .commit_a0(a0_b), .ext_stop(es_b), .running(run_b),
    .finish(fin_b), .cause(cause_b), .exit_code(exit_b), .stop_pc(spc_b),
    .inst_cnt(inst_b), .cycle_cnt(ccnt_b)
  );

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] exit_code;
    logic [31:0] stop_pc;
    logic [31:0] inst;
    logic [31:0] ccnt;
    int          fin_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor A: on each rising finish, pop the expected end-of-run record and compare.
  logic fin_a_q = 1'b0;
  always @(negedge clk) begin
    if (fin_a === 1'b1 && fin_a_q !== 1'b1) begin
      if (q_a.size() == 0) begin
        n_chk++;
        $display("FAIL a_unexpected_finish: got finish=1 at cycle %0d expected none", cyc);
      end else begin
        ea = q_a.pop_front();
        chk("a_fin_cycle", 32'(cyc), 32'(ea.fin_cyc));
        chk("a_cause",     32'(cause_a), 32'(ea.cause));
        chk("a_exit_code", exit_a, ea.exit_code);
        chk("a_stop_pc",   spc_a, ea.stop_pc);
        chk("a_inst_cnt",  inst_a, ea.inst);
        chk("a_cycle_cnt", ccnt_a, ea.ccnt);
        chk("a_running",   32'(run_a), 32'd0);
      end
    end
    fin_a_q <= fin_a;
  end

  // Monitor B: same scoreboard check for the no-drain, narrow-counter instance.
  logic fin_b_q = 1'b0;
  always @(negedge clk) begin
    if (fin_b === 1'b1 && fin_b_q !== 1'b1) begin
      if (q_b.size() == 0) begin
        n_chk++;
        $display("FAIL b_unexpected_finish: got finish=1 at cycle %0d expected none", cyc);
      end else begin
        eb = q_b.pop_front();
        chk("b_fin_cycle", 32'(cyc), 32'(eb.fin_cyc));
        chk("b_cause",     32'(cause_b), 32'(eb.cause));
        chk("b_exit_code", exit_b, eb.exit_code);
        chk("b_stop_pc",   spc_b, eb.stop_pc);
        chk("b_inst_cnt",  32'(inst_b), eb.inst);
        chk("b_cycle_cnt", 32'(ccnt_b), eb.ccnt);
        chk("b_running",   32'(run_b), 32'd0);
      end
    end
    fin_b_q <= fin_b;
  end

  // Drive one cycle of stimulus on the falling edge; sampled at the next rising edge.
  task automatic drive(input bit sel, input logic cv, input logic brk,
                       input logic [31:0] pc, input logic [31:0] a0, input logic es);
    @(negedge clk);
    if (sel) begin cv_b = cv; brk_b = brk; pc_b = pc; a0_b = a0; es_b = es; end
    else     begin cv_a = cv; brk_a = brk; pc_a = pc; a0_a = a0; es_a = es; end
  endtask

  task automatic idle(input bit sel, input logic es);
    drive(sel, 1'b0, 1'bx, 32'hxxxxxxxx, 32'hxxxxxxxx, es);
  endtask

  task automatic assert_rst(input bit sel);
    @(negedge clk);
    if (sel) begin rst_b = 1'b1; cv_b = 1'b0; es_b = 1'b0; end
    else     begin rst_a = 1'b1; cv_a = 1'b0; es_a = 1'b0; end
  endtask

  task automatic release_rst(input bit sel, output int rel);
    @(negedge clk);
    if (sel) rst_b = 1'b0;
    else     rst_a = 1'b0;
    rel = cyc + 1;
  endtask

  task automatic chk_rst_a();
    #1;
    chk("a_rst_running", 32'(run_a), 32'd1);
    chk("a_rst_finish",  32'(fin_a), 32'd0);
    chk("a_rst_cause",   32'(cause_a), 32'd0);
    chk("a_rst_exit",    exit_a, 32'd0);
    chk("a_rst_stop_pc", spc_a, 32'd0);
    chk("a_rst_inst",    inst_a, 32'd0);
    chk("a_rst_cycle",   ccnt_a, 32'd0);
  endtask

  task automatic wait_fin(input bit sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel ? fin_b : fin_a) === 1'b1) break;
      @(negedge clk);
    end
    if ((sel ? fin_b : fin_a) !== 1'b1) begin
      n_chk++;
      $display("FAIL %s_finish_timeout: got finish=0 after %0d cycles expected 1",
               sel ? "b" : "a", budget);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int   rel;
    int   t;
    int   ncom;
    exp_t e;

    #1 rst_b = 1'b1;

    // Test 1: ten commits then BREAK at 0x1c000028 with a0=0
    assert_rst(0);
    chk_rst_a();
    release_rst(0, rel);
    for (int i = 0; i < 10; i++) drive(0, 1'b1, 1'b0, 32'h1c000000 + 32'(4 * i), 32'(i), 1'b0);
    drive(0, 1'b1, 1'b1, 32'h1c000028, 32'h0, 1'b0);
    t = cyc + 1;
    e = '{cause: 2'd1, exit_code: 32'h0, stop_pc: 32'h1c000028, inst: 32'd11,
          ccnt: 32'(t + 4 - rel + 1), fin_cyc: t + 5};
    q_a.push_back(e);
    idle(0, 1'b0);
    wait_fin(0, 50);

    // Test 2: BREAK with a0=5 together with ext_stop; ext_stop and commits held in DRAIN
    assert_rst(0);
    release_rst(0, rel);
    drive(0, 1'b1, 1'b1, 32'h1c000200, 32'h5, 1'b1);
    t = cyc + 1;
    e = '{cause: 2'd1, exit_code: 32'h5, stop_pc: 32'h1c000200, inst: 32'd1,
          ccnt: 32'(t + 4 - rel + 1), fin_cyc: t + 5};
    q_a.push_back(e);
    for (int i = 0; i < 6; i++) drive(0, 1'b1, 1'b1, 32'h1c000300 + 32'(4 * i), 32'h77, 1'b1);
    idle(0, 1'b0);
    wait_fin(0, 50);
    chk("a_t2_finish_sticky", 32'(fin_a), 32'd1);

    // Test 3: watchdog after last commit at 0x1c000100
    assert_rst(0);
    release_rst(0, rel);
    drive(0, 1'b1, 1'b0, 32'h1c0000f8, 32'h1, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h1c0000fc, 32'h2, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h1c000100, 32'h3, 1'b0);
    t = cyc + 1 + 16;
    e = '{cause: 2'd3, exit_code: 32'h0, stop_pc: 32'h1c000100, inst: 32'd3,
          ccnt: 32'(t + 4 - rel + 1), fin_cyc: t + 5};
    q_a.push_back(e);
    idle(0, 1'b0);
    wait_fin(0, 100);

    // Test 4: commit every 15th cycle for 1000 cycles keeps the watchdog quiet
    assert_rst(0);
    release_rst(0, rel);
    ncom = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 15 == 0) begin
        drive(0, 1'b1, 1'b0, 32'h1c001000 + 32'(4 * i), 32'h0, 1'b0);
        ncom++;
      end else begin
        idle(0, 1'b0);
      end
    end
    @(negedge clk);
    chk("a_t4_running", 32'(run_a), 32'd1);
    chk("a_t4_finish",  32'(fin_a), 32'd0);
    chk("a_t4_cause",   32'(cause_a), 32'd0);
    chk("a_t4_inst",    inst_a, 32'd67);
    chk("a_t4_cycle",   ccnt_a, 32'(cyc - rel + 1));

    // Test 5: one-cycle ext_stop, reset two cycles into DRAIN, then a normal BREAK
    idle(0, 1'b1);
    idle(0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("a_t5_drain_running", 32'(run_a), 32'd0);
    chk("a_t5_drain_finish",  32'(fin_a), 32'd0);
    chk("a_t5_drain_cause",   32'(cause_a), 32'd2);
    chk("a_t5_drain_stop_pc", spc_a, 32'h1c001000 + 32'(4 * 990));
    rst_a = 1'b1;
    chk_rst_a();
    release_rst(0, rel);
    drive(0, 1'b1, 1'b0, 32'h1c000400, 32'h0, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h1c000404, 32'h0, 1'b0);
    drive(0, 1'b1, 1'b1, 32'h1c000408, 32'h2a, 1'b0);
    t = cyc + 1;
    e = '{cause: 2'd1, exit_code: 32'h2a, stop_pc: 32'h1c000408, inst: 32'd3,
          ccnt: 32'(t + 4 - rel + 1), fin_cyc: t + 5};
    q_a.push_back(e);
    idle(0, 1'b0);
    wait_fin(0, 50);

    // Test 6: no drain, 4-bit counters saturate at 15
    assert_rst(1);
    #1;
    chk("b_rst_running", 32'(run_b), 32'd1);
    chk("b_rst_finish",  32'(fin_b), 32'd0);
    chk("b_rst_inst",    32'(inst_b), 32'd0);
    release_rst(1, rel);
    for (int i = 0; i < 20; i++) drive(1, 1'b1, 1'b0, 32'h1c000000 + 32'(4 * i), 32'h0, 1'b0);
    @(negedge clk);
    chk("b_t6_inst_sat", 32'(inst_b), 32'd15);
    chk("b_t6_running",  32'(run_b), 32'd1);
    drive(1, 1'b1, 1'b1, 32'h1c000050, 32'h9, 1'b0);
    t = cyc + 1;
    e = '{cause: 2'd1, exit_code: 32'h9, stop_pc: 32'h1c000050, inst: 32'd15,
          ccnt: ((t - rel + 1) > 15) ? 32'd15 : 32'(t - rel + 1), fin_cyc: t + 1};
    q_b.push_back(e);
    idle(1, 1'b0);
    wait_fin(1, 20);

    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
